// File: rtl/ftch_dec_pkg.sv
// Fetch-to-decode shared definitions.
// Holds the packet handed from fetch to decode, the default reset fetch
// address and the default combined depth of in-flight requests plus
// buffered packets.
package ftch_dec_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ftch_dec_pkt_t;

  localparam logic [31:0] FTCH_RESET_PC = 32'hBFC0_0000;
  localparam int          FTCH_DEPTH    = 2;
  localparam int          FTCH_PKT_W    = $bits(ftch_dec_pkt_t);

endpackage

// File: rtl/ftch_fifo.sv
// Small synchronous FIFO used both as the request tag queue and as the
// output packet buffer of the fetch stage.
// Ports:
//   clk, reset       clock, asynchronous active-high reset (pointers/count)
//   flush            synchronous clear of all entries, wins over wr/rd
//   wr_en, wr_data   push; accepted when not full or when popping the same cycle
//   rd_en, rd_data   pop; rd_data always shows the head entry
//   cnt, empty, full occupancy status
module ftch_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  cnt,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_wr;
  logic              do_rd;

  // Pointers wrap at DEPTH so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ftch_stage.sv
// Instruction fetch stage: issues word-aligned requests to instruction
// memory, pairs in-order responses with their PCs and buffers packets for
// decode. Redirects flush buffered work and discard stale responses.
// Optional feature macro: FTCH_STAGE_PERF_EN adds ftch_stall_cnt.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   redirect_vld, redirect_pc          branch/exception redirect
//   imem_req_vld/rdy/addr              request channel to instruction memory
//   imem_rsp_vld/data                  in-order, non-stallable responses
//   ftch_dec_vld/rdy/pkt               packet channel to decode
//   ftch_stall_cnt (FTCH_STAGE_PERF_EN) saturating decode back-pressure count
module ftch_stage
  import ftch_dec_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FTCH_RESET_PC,
  parameter int          DEPTH    = FTCH_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          redirect_vld,
  input  logic [31:0]   redirect_pc,
  output logic          imem_req_vld,
  input  logic          imem_req_rdy,
  output logic [31:0]   imem_req_addr,
  input  logic          imem_rsp_vld,
  input  logic [31:0]   imem_rsp_data,
  output logic          ftch_dec_vld,
  input  logic          ftch_dec_rdy,
  output ftch_dec_pkt_t ftch_dec_pkt
`ifdef FTCH_STAGE_PERF_EN
  ,
  output logic [31:0]   ftch_stall_cnt
`endif
);

  localparam int             CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W:0]   occupancy;
  logic             req_fire;
  logic             dec_fire;
  logic             rsp_keep;
  logic             fifo_empty;
  logic [31:0]      tag_pc;
  ftch_dec_pkt_t    rsp_pkt;
  ftch_dec_pkt_t    fifo_head;

  logic [1:0]       redirect_pc_unused;
  logic [CNT_W-1:0] tag_cnt_unused;
  logic             tag_empty_unused;
  logic             tag_full_unused;
  logic             fifo_full_unused;

  assign redirect_pc_unused = redirect_pc[1:0];

  // Request side: throttle on requests outstanding plus packets buffered.
  // Gating with reset keeps the request quiet while reset is held.
  assign occupancy     = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign imem_req_vld  = !reset && !redirect_vld && (occupancy < DEPTH_V);
  assign imem_req_addr = fetch_pc;
  assign req_fire      = imem_req_vld && imem_req_rdy;

  // Response side: only responses to requests issued since the last
  // redirect are kept; stale ones are counted off via drop_cnt.
  assign rsp_keep = imem_rsp_vld && !redirect_vld && (drop_cnt == '0);

  assign rsp_pkt.pc    = tag_pc;
  assign rsp_pkt.instr = imem_rsp_data;

  // Decode side: the packet reads as zero whenever the buffer is empty.
  assign ftch_dec_vld = !fifo_empty && !redirect_vld;
  assign dec_fire     = ftch_dec_vld && ftch_dec_rdy;
  assign ftch_dec_pkt = fifo_empty ? '0 : fifo_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      if (redirect_vld)  fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (req_fire) fetch_pc <= fetch_pc + 32'd4;

      case ({req_fire, imem_rsp_vld})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase

      // On redirect every request still outstanding after this cycle is
      // stale. That equals the old drop count plus the newly stale live
      // requests, so a repeated redirect accumulates correctly.
      if (redirect_vld)
        drop_cnt <= inflight - CNT_W'(imem_rsp_vld);
      else if (imem_rsp_vld && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

  // Tag queue holds the PC of every live request. It is flushed on redirect
  // and stale responses never pop it.
  ftch_fifo #(
    .DATA_W (32),
    .DEPTH  (DEPTH)
  ) u_tag_q (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_vld),
    .wr_en   (req_fire),
    .wr_data (fetch_pc),
    .rd_en   (rsp_keep),
    .rd_data (tag_pc),
    .cnt     (tag_cnt_unused),
    .empty   (tag_empty_unused),
    .full    (tag_full_unused)
  );

  // Output buffer: response is registered here, so decode sees it the
  // cycle after the response.
  ftch_fifo #(
    .DATA_W (FTCH_PKT_W),
    .DEPTH  (DEPTH)
  ) u_out_q (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_vld),
    .wr_en   (rsp_keep),
    .wr_data (rsp_pkt),
    .rd_en   (dec_fire),
    .rd_data (fifo_head),
    .cnt     (fifo_cnt),
    .empty   (fifo_empty),
    .full    (fifo_full_unused)
  );

`ifdef FTCH_STAGE_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              ftch_stall_cnt <= '0;
    else if (ftch_dec_vld && !ftch_dec_rdy) ftch_stall_cnt <= sat_inc(ftch_stall_cnt);
  end
`endif

endmodule

// File: tb/tb_ftch_stage.sv
// Directed bench for ftch_stage with an in-order memory model of
// configurable latency and a packet scoreboard.
module tb_ftch_stage;
  import ftch_dec_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic          clk;
  logic          reset;
  logic          redirect_vld;
  logic [31:0]   redirect_pc;
  logic          imem_req_vld;
  logic          imem_req_rdy;
  logic [31:0]   imem_req_addr;
  logic          imem_rsp_vld;
  logic [31:0]   imem_rsp_data;
  logic          ftch_dec_vld;
  logic          ftch_dec_rdy;
  ftch_dec_pkt_t ftch_dec_pkt;
`ifdef FTCH_STAGE_PERF_EN
  logic [31:0]   ftch_stall_cnt;
`endif

  ftch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_vld  (redirect_vld),
    .redirect_pc   (redirect_pc),
    .imem_req_vld  (imem_req_vld),
    .imem_req_rdy  (imem_req_rdy),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_vld  (imem_rsp_vld),
    .imem_rsp_data (imem_rsp_data),
    .ftch_dec_vld  (ftch_dec_vld),
    .ftch_dec_rdy  (ftch_dec_rdy),
    .ftch_dec_pkt  (ftch_dec_pkt)
`ifdef FTCH_STAGE_PERF_EN
    ,
    .ftch_stall_cnt(ftch_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } pend_t;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          lat         = 1;
  int          epoch       = 0;
  int          stall_exp   = 0;
  pend_t       pend[$];
  logic [63:0] sb[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] exp_pc;
  logic [31:0] cur_addr;
  int          cur_ep;
  logic        stable_chk;
  logic [63:0] last_pkt;
  logic        want_first;
  logic        got_first;
  logic [31:0] first_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    sb.delete();
    imem_rsp_vld  = 1'b0;
    imem_rsp_data = '0;
    exp_pc        = RST_PC;
    stable_chk    = 1'b0;
    stall_exp     = 0;
    epoch++;
  endtask

  // One clock: evaluate at the falling edge, then drive the memory model
  // just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (reset) begin
      chk("rst_req_vld", imem_req_vld, 0);
      chk("rst_dec_vld", ftch_dec_vld, 0);
      chk("rst_pkt", ftch_dec_pkt, 0);
`ifdef FTCH_STAGE_PERF_EN
      chk("rst_stall_cnt", ftch_stall_cnt, 0);
`endif
    end else begin
      chk("req_vld", imem_req_vld,
          ((pend.size() + int'(imem_rsp_vld) + sb.size()) < DEPTH) && !redirect_vld);
      chk("dec_vld", ftch_dec_vld, (sb.size() != 0) && !redirect_vld);
      if (stable_chk) chk("pkt_stable", ftch_dec_pkt, last_pkt);
      if (ftch_dec_vld && ftch_dec_rdy && sb.size() != 0) begin
        chk("pkt", ftch_dec_pkt, sb.pop_front());
        pop_log.push_back(ftch_dec_pkt.pc);
        if (want_first) begin
          first_pc   = ftch_dec_pkt.pc;
          want_first = 1'b0;
          got_first  = 1'b1;
        end
      end
      stable_chk = ftch_dec_vld && !ftch_dec_rdy;
      last_pkt   = ftch_dec_pkt;
      if (ftch_dec_vld && !ftch_dec_rdy) stall_exp++;
      if (imem_req_vld && imem_req_rdy) begin
        chk("req_addr", imem_req_addr, exp_pc);
        pend.push_back('{addr: imem_req_addr, ep: epoch, due: cyc + lat});
        req_log.push_back(imem_req_addr);
        exp_pc = exp_pc + 32'd4;
      end
      if (imem_rsp_vld && !redirect_vld && cur_ep == epoch)
        sb.push_back({cur_addr, imem_rsp_data});
      if (redirect_vld) begin
        epoch++;
        exp_pc = {redirect_pc[31:2], 2'b00};
        sb.delete();
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!reset && pend.size() != 0 && pend[0].due <= cyc) begin
      pend_t p;
      p             = pend.pop_front();
      imem_rsp_vld  = 1'b1;
      imem_rsp_data = mem_word(p.addr);
      cur_addr      = p.addr;
      cur_ep        = p.ep;
    end else begin
      imem_rsp_vld  = 1'b0;
      imem_rsp_data = $urandom;
    end
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    redirect_vld = 1'b0;
    redirect_pc  = '0;
    imem_req_rdy = 1'b0;
    ftch_dec_rdy = 1'b0;
    want_first   = 1'b0;
    got_first    = 1'b0;
    first_pc     = '0;
    cur_addr     = '0;
    cur_ep       = -1;
    last_pkt     = '0;
    model_reset();
    repeat (3) tick();

    // Reset release: first request goes to the reset PC.
    reset        = 1'b0;
    imem_req_rdy = 1'b1;
    ftch_dec_rdy = 1'b1;
    lat          = 1;
    #1;
    chk("rel_req_vld", imem_req_vld, 1);
    chk("rel_req_addr", imem_req_addr, RST_PC);
    pop_log.delete();
    repeat (12) tick();
    chk("seq_pc0", pop_log[0], 32'hBFC0_0000);
    chk("seq_pc1", pop_log[1], 32'hBFC0_0004);
    chk("seq_pc2", pop_log[2], 32'hBFC0_0008);

    // Decode stall for 10 cycles.
    n = 0;
    while (!ftch_dec_vld && n < 20) begin tick(); n++; end
    chk("stall_start_vld", ftch_dec_vld, 1);
    ftch_dec_rdy = 1'b0;
    repeat (10) tick();
    chk("stall_no_req", imem_req_vld, 0);
    chk("stall_dec_vld", ftch_dec_vld, 1);
`ifdef FTCH_STAGE_PERF_EN
    chk("stall_cnt", ftch_stall_cnt, 32'd10);
`endif
    ftch_dec_rdy = 1'b1;
    repeat (6) tick();

    // Refill the buffer, then redirect while it is full.
    ftch_dec_rdy = 1'b0;
    repeat (4) tick();
    chk("full_dec_vld", ftch_dec_vld, 1);
    redirect_vld = 1'b1;
    redirect_pc  = 32'h0000_1000;
    ftch_dec_rdy = 1'b1;
    #1;
    chk("redir_no_xfer", ftch_dec_vld, 0);
    chk("redir_no_req", imem_req_vld, 0);
    tick();
    redirect_vld = 1'b0;
    chk("flushed_vld", ftch_dec_vld, 0);
    chk("flushed_drop", dut.drop_cnt, 0);
    chk("flushed_addr", imem_req_addr, 32'h0000_1000);

    // Redirect with two requests in flight and no response this cycle.
    lat = 3;
    n = 0;
    while (!(pend.size() == 2 && !imem_rsp_vld) && n < 30) begin tick(); n++; end
    chk("two_inflight", pend.size() == 2 && !imem_rsp_vld, 1);
    redirect_vld = 1'b1;
    redirect_pc  = 32'h0040_0010;
    want_first   = 1'b1;
    got_first    = 1'b0;
    tick();
    redirect_vld = 1'b0;
    chk("drop_two", dut.drop_cnt, 2);
    n = 0;
    while (!got_first && n < 40) begin tick(); n++; end
    chk("after_redir_seen", got_first, 1);
    chk("after_redir_pc", first_pc, 32'h0040_0010);

    // Redirect in the same cycle as a response with two outstanding.
    lat = 2;
    n = 0;
    while (!(imem_rsp_vld && pend.size() == 1) && n < 30) begin tick(); n++; end
    chk("rsp_redir_setup", imem_rsp_vld && pend.size() == 1, 1);
    redirect_vld = 1'b1;
    redirect_pc  = 32'h0080_0020;
    tick();
    redirect_vld = 1'b0;
    chk("drop_one", dut.drop_cnt, 1);
    repeat (8) tick();

    // Unaligned redirect near the top of the address space wraps to zero.
    lat = 1;
    redirect_vld = 1'b1;
    redirect_pc  = 32'hFFFF_FFFE;
    req_log.delete();
    tick();
    redirect_vld = 1'b0;
    n = 0;
    while (req_log.size() < 2 && n < 30) begin tick(); n++; end
    chk("wrap_reqs", req_log.size() >= 2, 1);
    chk("wrap_addr0", req_log[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", req_log[1], 32'h0000_0000);
    repeat (6) tick();

    // Reset mid-stream with two requests in flight.
    lat = 3;
    n = 0;
    while (pend.size() != 2 && n < 30) begin tick(); n++; end
    chk("rst_two_inflight", pend.size(), 2);
    reset = 1'b1;
    #1;
    chk("midrst_req_vld", imem_req_vld, 0);
    chk("midrst_dec_vld", ftch_dec_vld, 0);
    chk("midrst_pkt", ftch_dec_pkt, 0);
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    lat   = 1;
    #1;
    chk("rerel_req_vld", imem_req_vld, 1);
    chk("rerel_req_addr", imem_req_addr, RST_PC);
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
